// File: rtl/divider_seq_if.sv
// Start/done handshake bundle for the sequential divider.
//   master : requester side  - drives start, signed_op, a, b
//   slave  : divider side    - drives ready, done, quotient, remainder,
//                              div_by_zero, overflow
`ifndef DEFAULT_WIDTH
`define DEFAULT_WIDTH 8
`endif

interface divider_seq_if #(parameter int N = `DEFAULT_WIDTH);
  logic         start;
  logic         signed_op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         ready;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;

  modport master (
    output start, signed_op, a, b,
    input  ready, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, signed_op, a, b,
    output ready, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/divider_seq.sv
// Multi-cycle restoring integer divider (DIV/REM unit beside addsub).
// One quotient bit per clock; signed operands are divided as magnitudes and
// the signs are restored on the final RUN edge.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  synchronous reset, active low
//   bus      divider_seq_if.slave: start/signed_op/a/b in,
//            ready/done/quotient/remainder/div_by_zero/overflow out
// Latency: start accepted at edge k -> done in the cycle after edge k+n.
// Divide-by-zero and signed MIN/-1 finish in one cycle.
`ifndef DEFAULT_WIDTH
`define DEFAULT_WIDTH 8
`endif

module divider_seq #(
  parameter int n = `DEFAULT_WIDTH
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  divider_seq_if.slave bus
);

  localparam int CW = (n > 2) ? $clog2(n) : 1;
  localparam logic [n-1:0] MIN = {1'b1, {(n-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [n-1:0]  r_rem;   // partial remainder
  logic [n-1:0]  r_dvd;   // dividend shifting out, quotient shifting in
  logic [n-1:0]  r_dsr;   // divisor magnitude
  logic          r_sop, r_sa, r_sb;
  logic [n-1:0]  r_quo, r_remo;
  logic          r_dz, r_ov;

  // ---- acceptance-time decode ----
  logic         w_accept, w_a_neg, w_b_neg, w_dz, w_ovf, w_fast;
  logic [n-1:0] w_mag_a, w_mag_b;

  assign w_accept = (r_state != S_RUN) && bus.start;
  assign w_a_neg  = bus.signed_op & bus.a[n-1];
  assign w_b_neg  = bus.signed_op & bus.b[n-1];
  // |MIN| wraps back to MIN, which read unsigned is exactly 2^(n-1).
  assign w_mag_a  = w_a_neg ? (n'(0) - bus.a) : bus.a;
  assign w_mag_b  = w_b_neg ? (n'(0) - bus.b) : bus.b;
  assign w_dz     = (bus.b == '0);
  assign w_ovf    = bus.signed_op && (bus.a == MIN) && (bus.b == '1);
  assign w_fast   = w_dz | w_ovf;

  // ---- one restoring step ----
  // The shifted remainder can reach 2^(n+1)-3 for unsigned divisors, so the
  // compare is done on n+1 bits; the surviving difference always fits n bits.
  logic [n:0]   w_shift;
  logic [n-1:0] w_diff, w_rem_nx, w_quo_nx, w_quo_fix, w_rem_fix;
  logic         w_ge;

  assign w_shift   = {r_rem, r_dvd[n-1]};
  assign w_ge      = (w_shift >= {1'b0, r_dsr});
  assign w_diff    = w_shift[n-1:0] - r_dsr;
  assign w_rem_nx  = w_ge ? w_diff : w_shift[n-1:0];
  assign w_quo_nx  = {r_dvd[n-2:0], w_ge};
  assign w_quo_fix = (r_sop & (r_sa ^ r_sb)) ? (n'(0) - w_quo_nx) : w_quo_nx;
  assign w_rem_fix = (r_sop & r_sa)          ? (n'(0) - w_rem_nx) : w_rem_nx;

  // ---- FSM ----
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) w_next = w_fast ? S_DONE : S_RUN;
        else           w_next = S_IDLE;
      end
      S_RUN:   if (r_cnt == '0) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // ---- datapath ----
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_rem  <= '0;
      r_dvd  <= '0;
      r_dsr  <= '0;
      r_sop  <= 1'b0;
      r_sa   <= 1'b0;
      r_sb   <= 1'b0;
      r_quo  <= '0;
      r_remo <= '0;
      r_dz   <= 1'b0;
      r_ov   <= 1'b0;
    end else if (w_accept) begin
      r_sop  <= bus.signed_op;
      r_sa   <= w_a_neg;
      r_sb   <= w_b_neg;
      r_dvd  <= w_mag_a;
      r_dsr  <= w_mag_b;
      r_rem  <= '0;
      r_cnt  <= CW'(n-1);
      // Fast paths load their final results now; otherwise clear until done.
      r_quo  <= w_dz ? '1    : (w_ovf ? MIN : '0);
      r_remo <= w_dz ? bus.a : '0;
      r_dz   <= w_dz;
      r_ov   <= w_ovf & ~w_dz;
    end else if (r_state == S_RUN) begin
      r_rem <= w_rem_nx;
      r_dvd <= w_quo_nx;
      if (r_cnt == '0) begin
        r_quo  <= w_quo_fix;
        r_remo <= w_rem_fix;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign bus.ready       = (r_state != S_RUN);
  assign bus.done        = (r_state == S_DONE);
  assign bus.quotient    = r_quo;
  assign bus.remainder   = r_remo;
  assign bus.div_by_zero = r_dz;
  assign bus.overflow    = r_ov;

endmodule

// File: tb/tb_divider_seq.sv
module tb_divider_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  divider_seq_if #(.N(8)) bus ();
  divider_seq #(.n(8)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  // Reference: plain integer arithmetic on the spec's rules.
  function automatic void model(input logic sop, input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] q, output logic [7:0] r,
                                output logic dz, output logic ov);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    dz = 1'b0; ov = 1'b0;
    if (b == 8'd0) begin
      q = 8'hFF; r = a; dz = 1'b1;
    end else if (!sop) begin
      q = a / b; r = a % b;
    end else if (sa == -128 && sb == -1) begin
      q = 8'h80; r = 8'h00; ov = 1'b1;
    end else begin
      q = 8'(sa / sb); r = 8'(sa % sb);
    end
  endfunction

  // Drives one request and waits (bounded) for done. lat = clock edges from
  // start to the cycle where done is seen.
  task automatic run_op(input logic sync, input logic sop, input logic [7:0] a,
                        input logic [7:0] b, output logic [7:0] q, output logic [7:0] r,
                        output logic dz, output logic ov, output int lat);
    if (sync) @(negedge clk);
    bus.start = 1'b1; bus.signed_op = sop; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
    lat = 1;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    q = bus.quotient; r = bus.remainder; dz = bus.div_by_zero; ov = bus.overflow;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.ready); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if ({bus.quotient, bus.remainder} !== 16'h0) begin errors++; $display("FAIL reset_results got %h/%h want 0/0", bus.quotient, bus.remainder); end
    checks++; if ({bus.div_by_zero, bus.overflow} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {bus.div_by_zero, bus.overflow}); end
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned();
    logic [7:0] q, r; logic dz, ov; int lat;
    run_op(1'b1, 1'b0, 8'd200, 8'd7, q, r, dz, ov, lat);
    checks++; if (q !== 8'd28 || r !== 8'd4) begin errors++; $display("FAIL u200_7 got %0d rem %0d want 28 rem 4", q, r); end
    checks++; if (lat !== 9) begin errors++; $display("FAIL u200_7_latency got %0d want 9", lat); end
    checks++; if ({dz, ov} !== 2'b00) begin errors++; $display("FAIL u200_7_flags got %b want 00", {dz, ov}); end
  endtask

  task automatic test_signed();
    logic [7:0] q, r; logic dz, ov; int lat;
    run_op(1'b1, 1'b1, 8'h9C, 8'd7, q, r, dz, ov, lat);   // -100 / 7
    checks++; if (q !== 8'hF2 || r !== 8'hFE) begin errors++; $display("FAIL sm100_7 got %h rem %h want f2 rem fe", q, r); end
    run_op(1'b1, 1'b1, 8'd100, 8'hF9, q, r, dz, ov, lat); // 100 / -7
    checks++; if (q !== 8'hF2 || r !== 8'h02) begin errors++; $display("FAIL s100_m7 got %h rem %h want f2 rem 02", q, r); end
    checks++; if (lat !== 9) begin errors++; $display("FAIL s100_m7_latency got %0d want 9", lat); end
  endtask

  task automatic test_div_zero();
    logic [7:0] q, r; logic dz, ov; int lat;
    run_op(1'b1, 1'b0, 8'h5A, 8'h00, q, r, dz, ov, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL dz_latency got %0d want 1", lat); end
    checks++; if (q !== 8'hFF || r !== 8'h5A) begin errors++; $display("FAIL dz_results got %h rem %h want ff rem 5a", q, r); end
    checks++; if ({dz, ov} !== 2'b10) begin errors++; $display("FAIL dz_flags got %b want 10", {dz, ov}); end
  endtask

  task automatic test_overflow();
    logic [7:0] q, r; logic dz, ov; int lat;
    run_op(1'b1, 1'b1, 8'h80, 8'hFF, q, r, dz, ov, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL ovf_latency got %0d want 1", lat); end
    checks++; if (q !== 8'h80 || r !== 8'h00 || {dz, ov} !== 2'b01) begin errors++; $display("FAIL ovf_results got %h rem %h flags %b want 80 rem 00 flags 01", q, r, {dz, ov}); end
    run_op(1'b1, 1'b0, 8'h80, 8'hFF, q, r, dz, ov, lat);
    checks++; if (q !== 8'h00 || r !== 8'h80 || {dz, ov} !== 2'b00) begin errors++; $display("FAIL u80_ff got %h rem %h flags %b want 00 rem 80 flags 00", q, r, {dz, ov}); end
  endtask

  task automatic test_busy();
    int lat;
    @(negedge clk);
    bus.start = 1'b1; bus.signed_op = 1'b0; bus.a = 8'd255; bus.b = 8'd16;
    @(negedge clk); bus.start = 1'b0; lat = 1;
    @(negedge clk); lat++;
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL busy_ready got %b want 0", bus.ready); end
    bus.start = 1'b1; bus.a = 8'd9; bus.b = 8'd3;
    @(negedge clk); bus.start = 1'b0; lat++;
    while (!bus.done && lat < 40) begin @(negedge clk); lat++; end
    checks++; if (lat !== 9) begin errors++; $display("FAIL busy_latency got %0d want 9", lat); end
    checks++; if (bus.quotient !== 8'd15 || bus.remainder !== 8'd15) begin errors++; $display("FAIL busy_result got %0d rem %0d want 15 rem 15", bus.quotient, bus.remainder); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q, r; logic dz, ov; int lat;
    run_op(1'b1, 1'b0, 8'd255, 8'd16, q, r, dz, ov, lat);
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_in_done got %b want 1", bus.ready); end
    run_op(1'b0, 1'b0, 8'd9, 8'd3, q, r, dz, ov, lat);   // issued in the DONE cycle
    checks++; if (lat !== 9) begin errors++; $display("FAIL b2b_latency got %0d want 9", lat); end
    checks++; if (q !== 8'd3 || r !== 8'd0) begin errors++; $display("FAIL b2b_result got %0d rem %0d want 3 rem 0", q, r); end
  endtask

  task automatic test_mid_reset();
    logic [7:0] q, r; logic dz, ov; int lat;
    @(negedge clk);
    bus.start = 1'b1; bus.signed_op = 1'b0; bus.a = 8'd200; bus.b = 8'd7;
    @(negedge clk); bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL midrst_state got ready=%b done=%b want 1/0", bus.ready, bus.done); end
    checks++; if ({bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow} !== 18'h0) begin errors++; $display("FAIL midrst_outputs got %h/%h/%b%b want zeros", bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow); end
    // The aborted op must not surface a late done.
    repeat (10) begin
      @(negedge clk);
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midrst_stray_done got %b want 0", bus.done); end
    end
    run_op(1'b1, 1'b0, 8'd10, 8'd3, q, r, dz, ov, lat);
    checks++; if (q !== 8'd3 || r !== 8'd1 || lat !== 9) begin errors++; $display("FAIL midrst_next got %0d rem %0d lat %0d want 3 rem 1 lat 9", q, r, lat); end
  endtask

  task automatic test_random();
    logic [7:0] q, r, eq, er, a, b; logic dz, ov, edz, eov, sop; int lat, elat;
    for (int i = 0; i < 60; i++) begin
      sop = 1'($urandom);
      a = 8'($urandom);
      b = 8'($urandom);
      case ($urandom_range(0, 9))
        0: b = 8'h00;
        1: begin a = 8'h80; b = 8'hFF; end
        2: b = 8'hFF;
        3: a = 8'h80;
        default: ;
      endcase
      model(sop, a, b, eq, er, edz, eov);
      elat = (edz || eov) ? 1 : 9;
      run_op(($urandom_range(0, 2) != 0), sop, a, b, q, r, dz, ov, lat);
      checks++;
      if (q !== eq || r !== er || dz !== edz || ov !== eov || lat !== elat) begin
        errors++;
        $display("FAIL rand%0d s=%b a=%h b=%h got q=%h r=%h dz=%b ov=%b lat=%0d want q=%h r=%h dz=%b ov=%b lat=%0d",
                 i, sop, a, b, q, r, dz, ov, lat, eq, er, edz, eov, elat);
      end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.signed_op = 1'b0; bus.a = '0; bus.b = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_busy();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
